// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 32-bit ALU between two requesters.
// Port 0 is typically the execute stage, port 1 the branch-target/PC adder.
// Pipeline: grant (combinational) -> issue registers (Op*) -> result registers.
// A grant in cycle t produces Valid/Result in cycle t+2; one op per cycle.
//
// Configuration macro: ALU_ARB_FIXED_PRIORITY_EN
//   defined   : port 0 always wins contention, port 1 may starve.
//   undefined : round-robin, the port not granted last wins contention.
//
// Handshake: ReqN is the requester's "valid"; GntN is the arbiter's "ready".
// An operation transfers at a rising edge where ReqN && GntN. While ReqN is
// high and GntN is low the requester holds ControlN/AN/BN stable. After a
// transfer the requester may drop ReqN or present a new operation. The result
// side has no backpressure: Valid is a one-cycle pulse the requester must
// capture.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [2:0]       Control0,
  input  logic [2:0]       Control1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             Valid,
  output logic             ResultId,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Error
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Issue stage registers
  logic             op_valid;
  logic             op_id;
  logic [2:0]       op_control;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  // Shared ALU outputs
  logic [WIDTH-1:0] alu_result;
  logic             alu_unknown;

  logic             any_gnt;

`ifndef ALU_ARB_FIXED_PRIORITY_EN
  // Priority pointer: port granted most recently. Reset to 1 so port 0
  // wins the first contention.
  logic last;

  // Pointer follows every grant, holds otherwise
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      last <= 1'b1;
    end else if (Gnt0) begin
      last <= 1'b0;
    end else if (Gnt1) begin
      last <= 1'b1;
    end
  end
`endif

  // Grant selection; never both high, both low during reset
  always_comb begin
    Gnt0 = 1'b0;
    Gnt1 = 1'b0;
    if (!RESET) begin
      if (Req0 && !Req1) begin
        Gnt0 = 1'b1;
      end else if (!Req0 && Req1) begin
        Gnt1 = 1'b1;
      end else if (Req0 && Req1) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
        Gnt0 = 1'b1;
`else
        if (last) begin
          Gnt0 = 1'b1;
        end else begin
          Gnt1 = 1'b1;
        end
`endif
      end
    end
  end

  assign any_gnt = Gnt0 | Gnt1;

  // Issue registers capture the winner's operation on a grant edge
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      op_valid   <= 1'b0;
      op_id      <= 1'b0;
      op_control <= 3'b000;
      op_a       <= '0;
      op_b       <= '0;
    end else begin
      op_valid <= any_gnt;
      if (Gnt0) begin
        op_id      <= 1'b0;
        op_control <= Control0;
        op_a       <= A0;
        op_b       <= B0;
      end else if (Gnt1) begin
        op_id      <= 1'b1;
        op_control <= Control1;
        op_a       <= A1;
        op_b       <= B1;
      end
    end
  end

  // Shared ALU evaluated from the issue registers; SLT is unsigned and SHL
  // uses the full shift amount so amounts of 32 or more yield zero
  always_comb begin
    alu_result  = '0;
    alu_unknown = 1'b0;
    case (op_control)
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      OP_SHL:  alu_result = op_a << op_b;
      default: begin
        alu_result  = '0;
        alu_unknown = 1'b1;
      end
    endcase
  end

  // Result registers: Valid/ResultId track the issue stage, Result/Zero only
  // load for a real operation, Error is sticky until reset
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      Valid    <= 1'b0;
      ResultId <= 1'b0;
      Result   <= '0;
      Zero     <= 1'b0;
      Error    <= 1'b0;
    end else begin
      Valid    <= op_valid;
      ResultId <= op_id;
      if (op_valid) begin
        Result <= alu_result;
        Zero   <= (alu_result == '0);
        if (alu_unknown) begin
          Error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed steps followed by constrained-random
// requester traffic, checked against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int W  = 32;
  localparam int EW = W + 3;   // {unknown, id, valid, result}

`ifdef ALU_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic         CLOCK = 1'b0;
  logic         RESET = 1'b1;
  logic         Req0 = 1'b0, Req1 = 1'b0;
  logic [2:0]   Control0 = 3'b000, Control1 = 3'b000;
  logic [W-1:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
  logic         Gnt0, Gnt1, Valid, ResultId, Zero, Error;
  logic [W-1:0] Result;

  always #5 CLOCK = ~CLOCK;

  alu_arbiter #(.WIDTH(W)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .Req0(Req0), .Req1(Req1),
    .Control0(Control0), .Control1(Control1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .Gnt0(Gnt0), .Gnt1(Gnt1),
    .Valid(Valid), .ResultId(ResultId),
    .Result(Result), .Zero(Zero), .Error(Error)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];     // one entry per cycle, delivered two cycles after the grant
  logic          m_known = 1'b0;
  logic          m_valid, m_id, m_zero, m_error, m_last;
  logic [W-1:0]  m_result;
  logic          e_g0, e_g1;
  logic          g0_prev = 1'b0, g1_prev = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Opcode table from the ALU definition: returns {unknown, result}
  function automatic logic [W:0] ref_alu(input logic [2:0] ctl, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    case (ctl)
      3'b010: return {1'b0, a + b};
      3'b110: return {1'b0, a - b};
      3'b000: return {1'b0, a & b};
      3'b001: return {1'b0, a | b};
      3'b111: begin
        r = (a < b) ? 32'd1 : 32'd0;
        return {1'b0, r};
      end
      3'b101: begin
        if (b >= 32) r = '0;
        else r = a << b[4:0];
        return {1'b0, r};
      end
      default: return {1'b1, r};
    endcase
  endfunction

  // One clock cycle: called at the falling edge with inputs already driven.
  // Checks grants and outputs mid-cycle, then advances the model at the
  // rising edge and returns at the next falling edge.
  task automatic tick();
    logic [EW-1:0] ent;
    logic [W:0]    r;
    #1;
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (!RESET) begin
      if (Req0 && (!Req1 || FIXED || m_last)) e_g0 = 1'b1;
      else if (Req1) e_g1 = 1'b1;
    end
    chk("gnt0", Gnt0, e_g0);
    chk("gnt1", Gnt1, e_g1);
    if (m_known) begin
      chk("valid", Valid, m_valid);
      chk("result", Result, m_result);
      chk("zero", Zero, m_zero);
      chk("error", Error, m_error);
    end
    if (m_known && m_valid) chk("result_id", ResultId, m_id);
    ent = '0;
    if (e_g0) begin
      r = ref_alu(Control0, A0, B0);
      ent = {r[W], 1'b0, 1'b1, r[W-1:0]};
    end else if (e_g1) begin
      r = ref_alu(Control1, A1, B1);
      ent = {r[W], 1'b1, 1'b1, r[W-1:0]};
    end
    @(posedge CLOCK);
    if (RESET) begin
      exp_q.delete();
      exp_q.push_back('0);
      m_known  = 1'b1;
      m_valid  = 1'b0;
      m_id     = 1'b0;
      m_result = '0;
      m_zero   = 1'b0;
      m_error  = 1'b0;
      m_last   = 1'b1;
      g0_prev  = 1'b0;
      g1_prev  = 1'b0;
    end else begin
      logic [EW-1:0] front;
      front   = exp_q.pop_front();
      m_valid = front[W];
      if (front[W]) begin
        m_id     = front[W+1];
        m_result = front[W-1:0];
        m_zero   = (front[W-1:0] == '0);
        if (front[W+2]) m_error = 1'b1;
      end
      exp_q.push_back(ent);
      if (e_g0) m_last = 1'b0;
      if (e_g1) m_last = 1'b1;
      g0_prev = e_g0;
      g1_prev = e_g1;
    end
    @(negedge CLOCK);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 3))
      0:       return W'($urandom_range(0, 40));
      1:       return '0;
      2:       return '1;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- directed + random stimulus ----------------
  initial begin
    @(negedge CLOCK);
    // reset
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    chk("rst_valid", Valid, 1'b0);
    chk("rst_result_id", ResultId, 1'b0);
    chk("rst_result", Result, 32'd0);
    chk("rst_zero", Zero, 1'b0);
    chk("rst_error", Error, 1'b0);

    // idle for 10 cycles
    for (int i = 0; i < 10; i++) tick();

    // single ADD from port 0
    Req0 = 1'b1; Control0 = 3'b010; A0 = 32'd5; B0 = 32'd7;
    tick();
    Req0 = 1'b0;
    tick();
    chk("add_valid", Valid, 1'b1);
    chk("add_id", ResultId, 1'b0);
    chk("add_result", Result, 32'd12);
    chk("add_zero", Zero, 1'b0);

    // port 1 SHL by 40 then by 31
    Req1 = 1'b1; Control1 = 3'b101; A1 = 32'd1; B1 = 32'd40;
    tick();
    B1 = 32'd31;
    tick();
    Req1 = 1'b0;
    chk("shl40_result", Result, 32'd0);
    chk("shl40_zero", Zero, 1'b1);
    tick();
    chk("shl31_result", Result, 32'h8000_0000);
    chk("shl31_id", ResultId, 1'b1);

    // contention: port 0 SUB 9-9, port 1 SLT 3<4, held 4 cycles
    Control0 = 3'b110; A0 = 32'd9; B0 = 32'd9;
    Control1 = 3'b111; A1 = 32'd3; B1 = 32'd4;
    for (int i = 0; i < 6; i++) begin
      Req0 = (i < 4);
      Req1 = (i < 4);
      #1;
      if (i < 4) chk("cont_gnt0", Gnt0, FIXED ? 1'b1 : ((i % 2) == 0));
      if (i >= 2) begin
        chk("cont_valid", Valid, 1'b1);
        chk("cont_id", ResultId, FIXED ? 1'b0 : ((i % 2) == 1));
        chk("cont_result", Result, (!FIXED && (i % 2) == 1) ? 32'd1 : 32'd0);
      end
      tick();
    end

    // unknown opcode sets sticky Error
    Req0 = 1'b1; Control0 = 3'b100; A0 = 32'd3; B0 = 32'd4;
    tick();
    Req0 = 1'b0;
    tick();
    chk("unk_valid", Valid, 1'b1);
    chk("unk_result", Result, 32'd0);
    chk("unk_zero", Zero, 1'b1);
    chk("unk_error", Error, 1'b1);
    Req0 = 1'b1; Control0 = 3'b010; A0 = 32'd1; B0 = 32'd1;
    tick();
    Req0 = 1'b0;
    tick();
    chk("unk_hold_result", Result, 32'd2);
    chk("unk_hold_error", Error, 1'b1);

    // grant then reset mid-flight
    Req0 = 1'b1; Control0 = 3'b010; A0 = 32'd2; B0 = 32'd2;
    tick();
    Req0 = 1'b0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("flush_valid_t2", Valid, 1'b0);
    chk("flush_error", Error, 1'b0);
    tick();
    chk("flush_valid_t3", Valid, 1'b0);
    Req0 = 1'b1; Req1 = 1'b1;
    #1;
    chk("post_rst_gnt0", Gnt0, 1'b1);
    chk("post_rst_gnt1", Gnt1, 1'b0);
    tick();
    Req0 = 1'b0; Req1 = 1'b0;
    tick();
    tick();

    // random traffic obeying the hold-while-waiting rule
    for (int n = 0; n < 400; n++) begin
      RESET = ($urandom_range(0, 99) == 0);
      if (!(Req0 && !g0_prev)) begin
        Req0     = ($urandom_range(0, 99) < 60);
        Control0 = 3'($urandom_range(0, 7));
        A0       = rnd_operand();
        B0       = rnd_operand();
      end
      if (!(Req1 && !g1_prev)) begin
        Req1     = ($urandom_range(0, 99) < 60);
        Control1 = 3'($urandom_range(0, 7));
        A1       = rnd_operand();
        B1       = rnd_operand();
      end
      tick();
    end
    RESET = 1'b0; Req0 = 1'b0; Req1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter that shares a single 32-bit ALU between two requesters, e.g. the execute stage (port 0) and the branch-target/PC adder path (port 1). It grants at most one request per cycle, registers the winner's operation, evaluates it on the shared ALU and returns a registered result tagged with the requester ID. Throughput is one operation per cycle; latency is fixed.

## Interface
Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.

Ports:
- CLOCK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- Req0 / Req1  in  1  request from port 0 / port 1.
- Control0 / Control1  in  3  ALU opcode: ADD 010, SUB 110, AND 000, OR 001, SLT 111, SHL 101.
- A0, B0 / A1, B1  in  32  operands for each port.
- Gnt0 / Gnt1  out  1  combinational grant; the operation is accepted at the next edge.
- Valid  out  1  one-cycle pulse; Result/Zero/ResultId are meaningful.
- ResultId  out  1  port that issued the result (0 or 1).
- Result  out  32  registered ALU result.
- Zero  out  1  registered (Result == 0).
- Error  out  1  sticky; set when an unknown opcode is accepted.

## Operation
- Grant logic, combinational:
  - Only Req0: Gnt0=1. Only Req1: Gnt1=1.
  - Both: the port not granted last wins.
  - Never both grants high. Gnt is forced low while RESET=1.
- Requester rules:
  - Hold Control/A/B stable while Req is high.
  - Operands are sampled at the edge where the port's Gnt is high.
  - The requester may drop Req or present a new op in the next cycle.
- Priority pointer Last (1 bit):
  - Updated to the granted port on every grant edge.
  - Unchanged in cycles with no grant.
- Stage 1 (issue) registers: OpValid, OpId, OpControl, OpA, OpB, loaded on a grant edge. OpValid=0 when no grant.
- Stage 2 (result) registers, evaluated from the Op registers:
  - ADD A+B; SUB A−B (mod 2^32).
  - AND, OR bitwise.
  - SLT: unsigned A<B gives 1, else 0.
  - SHL: A<<B using the full 32-bit B, so B≥32 gives 0.
- Unknown opcode (011, 100): Result=0, Zero=1, Valid still pulses, Error set.
- No backpressure. Requesters must capture the result in the Valid cycle.

## Timing
- Reset values: Valid=0, ResultId=0, Result=0, Zero=0, Error=0, OpValid=0, Last=1 (port 0 wins the first contention).
- Latency: Gnt high in cycle t, so Valid/Result are present in cycle t+2.
- Back-to-back grants in t and t+1 give Valid in t+2 and t+3.
- Continuous contention: grants alternate 0,1,0,1,…
- Single continuous requester: granted every cycle; Last stays on that port.
- Output registers:
  - Valid and ResultId follow OpValid and OpId.
  - Result and Zero load only when OpValid=1 and otherwise hold their last value.
- RESET mid-operation: in-flight Op/result registers are cleared. Valid=0 in the cycle after RESET, and no pending op completes.
- Error clears only on RESET.

## Configuration
- ALU_ARB_FIXED_PRIORITY_EN defined: port 0 always wins contention; Last is unused; port 1 can starve.
- Undefined (default): round-robin as above.

## Test plan
- Reset release, idle → Valid=0, Error=0, Gnt0=Gnt1=0 for 10 cycles.
- Req0 ADD A0=5 B0=7 for one cycle t → Gnt0=1 in t; in t+2 Valid=1, ResultId=0, Result=12, Zero=0.
- Req0 and Req1 both held 4 cycles (port 0 SUB 9−9, port 1 SLT 3<4) → grants 0,1,0,1. Results: Result=0 with Zero=1 for port 0; Result=1 for port 1. ResultIds 0,1,0,1 in consecutive cycles.
- Req1 SHL A1=1 B1=40, then SHL A1=1 B1=31 → Result=0 then 0x80000000.
- Req0 Control0=100 → Valid pulse, Result=0, Zero=1, Error=1 and held through later valid ops until RESET.
- Grant at t, RESET asserted at t+1 → no Valid at t+2 or later; next contention goes to port 0. With ALU_ARB_FIXED_PRIORITY_EN, repeat the contention test → Gnt0 every cycle, Gnt1 never.
